// File: rtl/fetch_predict_if.sv
// Fetch-stage bus: hazard/EX-stage controls in, IF/ID payload and debug counter out.
interface fetch_predict_if;
    logic        stallF;
    logic        redirect_E;
    logic [31:0] redirect_pc_E;
    logic        upd_valid_E;
    logic [31:0] upd_pc_E;
    logic        upd_taken_E;
    logic [31:0] upd_target_E;
    logic [31:0] pc_F;
    logic [31:0] pc4_F;
    logic        takenF;
    logic [31:0] pred_target_F;
    logic [31:0] mispred_cnt;

    // Pipeline control / EX training side
    modport master (
        output stallF, redirect_E, redirect_pc_E,
        output upd_valid_E, upd_pc_E, upd_taken_E, upd_target_E,
        input  pc_F, pc4_F, takenF, pred_target_F, mispred_cnt
    );

    // Fetch/predict unit side
    modport slave (
        input  stallF, redirect_E, redirect_pc_E,
        input  upd_valid_E, upd_pc_E, upd_taken_E, upd_target_E,
        output pc_F, pc4_F, takenF, pred_target_F, mispred_cnt
    );
endinterface

// File: rtl/fetch_predict_unit.sv
// IF-stage PC owner with direct-mapped BTB + 2-bit BHT next-PC prediction,
// EX-stage training/redirect, and a wrapping mispredict counter.
module fetch_predict_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    fetch_predict_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [1:0]       bht        [DEPTH];
    logic [DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0] btb_tag    [DEPTH];
    logic [29:0]      btb_target [DEPTH];

    logic [31:0]      pc_q;
    logic [31:0]      cnt_q;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;
    logic [31:0]      f_pc4;
    logic [31:0]      f_pred;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic [1:0]       u_ctr_old;
    logic [1:0]       u_ctr_new;

    // Alignment bits are dropped everywhere; kept only to make that explicit.
    logic             unused_low_bits;
    assign unused_low_bits = ^{bus.redirect_pc_E[1:0], bus.upd_target_E[1:0], bus.upd_pc_E[1:0]};

    // Lookup on the current fetch PC (reads the pre-update table contents)
    always_comb begin
        f_idx   = pc_q[IDX_W+1:2];
        f_tag   = pc_q[31:IDX_W+2];
        f_hit   = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        f_taken = f_hit && bht[f_idx][1];
        f_pc4   = pc_q + 32'd4;
        f_pred  = f_taken ? {btb_target[f_idx], 2'b00} : f_pc4;
    end

    // Saturating counter step for the entry being trained
    always_comb begin
        u_idx     = bus.upd_pc_E[IDX_W+1:2];
        u_tag     = bus.upd_pc_E[31:IDX_W+2];
        u_ctr_old = bht[u_idx];
        u_ctr_new = u_ctr_old;
        if (bus.upd_taken_E) begin
            if (u_ctr_old != 2'b11) u_ctr_new = u_ctr_old + 2'd1;
        end else begin
            if (u_ctr_old != 2'b00) u_ctr_new = u_ctr_old - 2'd1;
        end
    end

    // PC register: reset > redirect > stall > predicted next PC
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (bus.redirect_E) begin
            pc_q <= {bus.redirect_pc_E[31:2], 2'b00};
        end else if (!bus.stallF) begin
            pc_q <= f_pred;
        end
    end

    // Mispredict counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.redirect_E) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // BHT counters and BTB valid bits (reset-cleared state)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bht[i] <= CNT_INIT;
            end
            btb_valid <= '0;
        end else if (bus.upd_valid_E) begin
            bht[u_idx] <= u_ctr_new;
            if (bus.upd_taken_E) begin
                btb_valid[u_idx] <= 1'b1;
            end
        end
    end

    // BTB tag/target payload; meaningless until valid, so no reset
    always_ff @(posedge clk) begin
        if (!rst && bus.upd_valid_E && bus.upd_taken_E) begin
            btb_tag[u_idx]    <= u_tag;
            btb_target[u_idx] <= bus.upd_target_E[31:2];
        end
    end

    assign bus.pc_F          = pc_q;
    assign bus.pc4_F         = f_pc4;
    assign bus.takenF        = f_taken;
    assign bus.pred_target_F = f_pred;
    assign bus.mispred_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench for fetch_predict_unit: directed scenarios then random traffic,
// all checked against a per-index table model of the predictor.
module tb_fetch_predict_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          IDX_W    = 6;
    localparam int          DEPTH    = 1 << IDX_W;
    localparam int          CNT_INIT = 1;

    logic clk;
    logic rst;
    fetch_predict_if bus ();

    fetch_predict_unit #(
        .RESET_PC (RESET_PC),
        .IDX_W    (IDX_W),
        .CNT_INIT (2'(CNT_INIT))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-index counter, valid flag, last trained PC and target
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          m_ctr    [DEPTH];
    bit          m_valid  [DEPTH];
    logic [31:0] m_src_pc [DEPTH];
    logic [31:0] m_tgt    [DEPTH];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_src_pc[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2))) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name);
        chk({name, "_pc"},   bus.pc_F,                  m_pc);
        chk({name, "_pc4"},  bus.pc4_F,                 m_pc + 32'd4);
        chk({name, "_tkn"},  32'(bus.takenF),           32'(m_taken(m_pc)));
        chk({name, "_pred"}, bus.pred_target_F,         m_pred(m_pc));
        chk({name, "_cnt"},  bus.mispred_cnt,           m_cnt);
    endtask

    // Advance one clock; model applies the same inputs using pre-edge table contents
    task automatic tick();
        logic [31:0] npc;
        int i;
        if (rst)                  npc = RESET_PC;
        else if (bus.redirect_E)  npc = bus.redirect_pc_E & ~32'd3;
        else if (bus.stallF)      npc = m_pc;
        else                      npc = m_pred(m_pc);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_ctr[k]   = CNT_INIT;
                m_valid[k] = 1'b0;
            end
            m_cnt = '0;
        end else begin
            if (bus.redirect_E) m_cnt = m_cnt + 32'd1;
            if (bus.upd_valid_E) begin
                i = idx_of(bus.upd_pc_E);
                if (bus.upd_taken_E) begin
                    m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_valid[i]  = 1'b1;
                    m_src_pc[i] = bus.upd_pc_E;
                    m_tgt[i]    = bus.upd_target_E & ~32'd3;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end
        end
        m_pc = npc;
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utg);
        bus.stallF        = st;
        bus.redirect_E    = rd;
        bus.redirect_pc_E = rpc;
        bus.upd_valid_E   = uv;
        bus.upd_pc_E      = upc;
        bus.upd_taken_E   = ut;
        bus.upd_target_E  = utg;
    endtask

    initial begin
        m_pc  = '0;
        m_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m_ctr[k] = CNT_INIT; m_valid[k] = 1'b0; m_src_pc[k] = '0; m_tgt[k] = '0;
        end

        // 1: reset then free-running fetch
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_all("t1");
            chk("t1_pc_const", bus.pc_F, 32'(4 * i));
            chk("t1_tkn_const", 32'(bus.takenF), 32'd0);
            tick();
        end
        chk("t1_end_pc", bus.pc_F, 32'h10);

        // 2: train 0x10 -> 0x40 twice while stalled at 0x10
        drive(1, 0, 0, 1, 32'h10, 1, 32'h40);
        chk("t2_old_tkn", 32'(bus.takenF), 32'd0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_all("t2");
        chk("t2_tkn_const", 32'(bus.takenF), 32'd1);
        chk("t2_pred_const", bus.pred_target_F, 32'h40);
        tick();
        chk("t2_next_pc", bus.pc_F, 32'h40);

        // 3: redirect beats stall, then stall holds
        drive(1, 1, 32'h83, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("t3_pc", bus.pc_F, 32'h80);
        chk("t3_cnt", bus.mispred_cnt, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold", bus.pc_F, 32'h80);
        end

        // 4: detrain 0x10 to weakly not-taken, then one taken update restores it
        drive(1, 0, 0, 1, 32'h10, 0, 32'h0);
        tick();
        tick();
        drive(1, 1, 32'h10, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk_all("t4");
        chk("t4_tkn_const", 32'(bus.takenF), 32'd0);
        chk("t4_pred_const", bus.pred_target_F, 32'h14);
        drive(1, 0, 0, 1, 32'h10, 1, 32'h40);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("t4_restore", 32'(bus.takenF), 32'd1);

        // 5: alias at same index, different tag; same-cycle update shows old entry
        drive(1, 1, 32'h10 + (4 << IDX_W), 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk_all("t5a");
        chk("t5_alias_tkn", 32'(bus.takenF), 32'd0);
        drive(1, 1, 32'h10, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 32'h10, 0, 0);
        chk("t5_rbw_old", 32'(bus.takenF), 32'd1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("t5_rbw_new", 32'(bus.takenF), 32'd0);

        // 6: mid-run reset dominates everything, then PC wrap
        drive(1, 0, 0, 1, 32'h10, 1, 32'h40);
        tick();
        tick();
        chk("t6_trained", 32'(bus.takenF), 32'd1);
        rst = 1'b1;
        drive(0, 1, 32'h200, 1, 32'h10, 1, 32'h80);
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk_all("t6");
        chk("t6_pc_const", bus.pc_F, RESET_PC);
        chk("t6_cnt_const", bus.mispred_cnt, 32'd0);
        drive(1, 1, 32'h10, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("t6_cleared_tkn", 32'(bus.takenF), 32'd0);
        drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t6_wrap_pc4", bus.pc4_F, 32'd0);
        chk("t6_wrap_pred", bus.pred_target_F, 32'd0);
        tick();
        chk("t6_wrap_pc", bus.pc_F, 32'd0);

        // Random traffic over a small address window to force hits and aliasing
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  32'(($urandom_range(0, 1) << (IDX_W + 2)) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                  $urandom_range(0, 4) < 2,
                  32'(($urandom_range(0, 1) << (IDX_W + 2)) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0,
                  32'(($urandom_range(0, 1) << (IDX_W + 2)) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3)));
            chk_all("rnd");
            tick();
        end
        rst = 1'b0;
        chk_all("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
